// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide with HI/LO result registers.
// Busy is high for WIDTH+1 cycles per MULT/DIV; MTHI/MTLO write in one cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic             Sign,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               op_div_q, op_div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               div0_q, div0_d;
   logic [WIDTH-1:0]   araw_q, araw_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] prod_signed;
   logic [WIDTH-1:0]   quo_signed, rem_signed;

   always_comb begin
      mag_a       = (Sign && A[WIDTH-1]) ? -A : A;
      mag_b       = (Sign && B[WIDTH-1]) ? -B : B;
      // work_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
      mul_sum     = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, (work_q[0] ? mcand_q : {WIDTH{1'b0}})};
      div_shift   = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
      div_diff    = div_shift - {1'b0, mcand_q};
      prod_signed = neg_res_q ? -work_q : work_q;
      quo_signed  = neg_res_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
      rem_signed  = neg_rem_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];

      state_d   = state_q;
      cnt_d     = cnt_q;
      op_div_d  = op_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      araw_d    = araw_q;
      mcand_d   = mcand_q;
      work_d    = work_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (Start) begin
               if (!Op[1]) begin
                  op_div_d  = Op[0];
                  mcand_d   = Op[0] ? mag_b : mag_a;
                  work_d    = Op[0] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                  neg_res_d = Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                  neg_rem_d = Sign & A[WIDTH-1];
                  div0_d    = (B == {WIDTH{1'b0}});
                  araw_d    = A;
                  cnt_d     = '0;
                  busy_d    = 1'b1;
                  state_d   = RUN;
               end else if (!Op[0]) begin
                  hi_d = A;
               end else begin
                  lo_d = A;
               end
            end
         end
         RUN: begin
            if (op_div_q) begin
               // Quotient bit is set when the trial subtract does not borrow.
               work_d = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                         work_q[WIDTH-2:0], ~div_diff[WIDTH]};
            end else begin
               work_d = {mul_sum, work_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            if (!op_div_q) begin
               hi_d = prod_signed[2*WIDTH-1:WIDTH];
               lo_d = prod_signed[WIDTH-1:0];
            end else if (div0_q) begin
               hi_d = araw_q;
               lo_d = {WIDTH{1'b1}};
            end else begin
               hi_d = rem_signed;
               lo_d = quo_signed;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         op_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         araw_q    <= '0;
         mcand_q   <= '0;
         work_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_div_q  <= op_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         araw_q    <= araw_d;
         mcand_q   <= mcand_d;
         work_q    <= work_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign Busy = busy_q;
   assign Done = done_q;
   assign Hi   = hi_q;
   assign Lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO result registers, sitting in the EX stage beside the combinational ALU. It consumes the operation and signedness decoded upstream (the `Sign` bit produced alongside the ALU control code), runs a radix-2 shift-add multiply or restoring divide over `WIDTH` cycles, and raises `Busy` so the hazard unit stalls the pipeline. `Hi`/`Lo` feed the MFHI/MFLO forwarding path.

## Interface
- `WIDTH`, 32, operand and HI/LO width; product is 2*WIDTH.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request; sampled only in IDLE.
- `Op`  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- `Sign`  in  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU); ignored for MTHI/MTLO.
- `A`  in  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO data).
- `B`  in  WIDTH  rt operand (multiplier/divisor).
- `Busy`  out  1  registered; high while an operation is in flight.
- `Done`  out  1  registered; one-cycle pulse when Hi/Lo are updated by MULT/DIV.
- `Hi`  out  WIDTH  HI register.
- `Lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, `Start`=1, `Op`=MULT/DIV: latch |A|, |B| (magnitudes when `Sign`=1, raw otherwise), latch result-sign flags, clear counter, go RUN, `Busy`<=1.
- IDLE, `Start`=1, `Op`=MTHI: `Hi`<=A; MTLO: `Lo`<=A. Single cycle, stay IDLE, `Busy` and `Done` stay 0.
- RUN: one iteration per cycle (multiply: conditional add + shift; divide: trial subtract + shift, quotient bit = no-borrow). Counter 0..WIDTH-1; at WIDTH-1 go FIX.
- FIX: apply signs, write `Hi`/`Lo` atomically, `Done`<=1, `Busy`<=0, go IDLE.
- MULT: {Hi,Lo} = full 2*WIDTH product; signed result negated iff operand signs differ.
- DIV: Lo = quotient truncated toward zero; Hi = remainder with sign of dividend.
- Divide by zero: no special cycle count; Lo = all ones, Hi = A (raw dividend).
- Signed overflow (most-negative / -1): Lo = most-negative value, Hi = 0.
- `Hi`/`Lo` hold old values throughout RUN; never partially updated.
- `Start` while `Busy`=1 or in FIX: ignored, no queuing.

## Timing
- Reset (any time, asynchronous): state IDLE, counter 0, `Hi`=0, `Lo`=0, `Busy`=0, `Done`=0. Reset during RUN/FIX aborts; no `Done`.
- Start sampled at edge E0; RUN edges E1..E(WIDTH); FIX edge E(WIDTH+1).
- `Busy` high from after E0 until E(WIDTH+1): WIDTH+1 cycles (33 at default).
- `Hi`/`Lo` new values and `Done`=1 visible after E(WIDTH+1); `Done` clears after the next edge.
- Back-to-back: a `Start` in the cycle `Done` is high is accepted (state is IDLE).
- MTHI/MTLO: written value visible after the sampling edge; zero stall.

## Test plan
- Reset: drive reset low mid-stream -> `Hi`=`Lo`=0, `Busy`=`Done`=0 immediately, without a clock edge.
- MULT signed A=0xFFFFFFFD, B=7 -> `Busy` 33 cycles, `Done` pulse, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; MULTU A=0xFFFFFFFF, B=2 -> Hi=0x00000001, Lo=0xFFFFFFFE.
- DIV signed A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU A=0xFFFFFFFF, B=0x10 -> Lo=0x0FFFFFFF, Hi=0x0000000F.
- Corners: DIVU A=0x1234, B=0 -> Hi=0x00001234, Lo=0xFFFFFFFF; DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Control: Start MULT then re-assert Start with different operands at cycle 5 -> ignored, result matches first op; MTHI A=0xDEADBEEF in IDLE -> Hi=0xDEADBEEF next cycle, Lo unchanged, no `Busy`, no `Done`.
- Abort: Start DIV, assert reset at RUN cycle 10 -> outputs zero; after release, a new MULT 6*7 -> Lo=42, Hi=0 with normal latency.
